// File: rtl/free_list.sv
// rtl/free_list.sv - circular free list of physical register tags for rename/retire
// Optional feature: FREE_LIST_BYPASS_EN hands a same-cycle freed tag straight to dispatch when empty.
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  localparam int D    = NUM_PREGS - NUM_AREGS,
  localparam int PW   = $clog2(NUM_PREGS),
  localparam int AW   = $clog2(D),
  localparam int PTRW = AW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            dequeue_en,
  output logic [PW-1:0]   free_reg,
  output logic            empty,
  input  logic            enqueue_en,
  input  logic [PW-1:0]   enqueue_pr,
  input  logic            rollback_en,
  input  logic [PTRW-1:0] rollback_head,
  output logic [PTRW-1:0] head_ptr,
  output logic [PTRW-1:0] count,
  output logic            overflow
);

  logic [PW-1:0]   entries [D];
  logic [PTRW-1:0] head;
  logic [PTRW-1:0] tail;
  logic [PTRW-1:0] head_next;
  logic [PTRW-1:0] count_after;
  logic            list_empty;
  logic            bypass;
  logic            do_deq;
  logic            enq_valid;
  logic            has_room;

  assign count      = tail - head;
  assign list_empty = (count == '0);
  assign head_ptr   = head;

`ifdef FREE_LIST_BYPASS_EN
  assign bypass = list_empty && enqueue_en && (enqueue_pr != '0) && dequeue_en && !rollback_en;
`else
  assign bypass = 1'b0;
`endif

  assign free_reg = bypass ? enqueue_pr : entries[head[AW-1:0]];
  assign empty    = list_empty && !bypass;

  // Rollback wins over dequeue; fullness is judged against the head as it will be next cycle.
  assign do_deq      = dequeue_en && !list_empty && !rollback_en;
  assign head_next   = rollback_en ? rollback_head : (do_deq ? head + PTRW'(1) : head);
  assign count_after = tail - head_next;
  assign has_room    = (count_after < PTRW'(D));
  assign enq_valid   = enqueue_en && (enqueue_pr != '0) && !bypass;

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= PTRW'(D);
      overflow <= 1'b0;
      for (int i = 0; i < D; i++) begin
        entries[i] <= PW'(NUM_AREGS + i);
      end
    end else begin
      head <= head_next;
      if (enq_valid && has_room) begin
        entries[tail[AW-1:0]] <= enqueue_pr;
        tail <= tail + PTRW'(1);
      end
      if (enq_valid && !has_room) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, total physical registers.
REQ-002 SHALL have parameter NUM_AREGS, default 32, architectural registers; list depth D = NUM_PREGS-NUM_AREGS, a power of two.
REQ-003 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dequeue_en  input  1  dispatch consumes free_reg this cycle.
REQ-006 SHALL have port free_reg  output  log2(NUM_PREGS)  tag at head (dest_tag source for the reorder buffer).
REQ-007 SHALL have port empty  output  1  no free tag available.
REQ-008 SHALL have port enqueue_en  input  1  retire returns a tag (ROB update_free_list).
REQ-009 SHALL have port enqueue_pr  input  log2(NUM_PREGS)  tag being freed (ROB free_index).
REQ-010 SHALL have port rollback_en  input  1  branch mispredict restore.
REQ-011 SHALL have port rollback_head  input  log2(D)+1  head pointer checkpoint to restore.
REQ-012 SHALL have port head_ptr  output  log2(D)+1  current head pointer incl. wrap bit, checkpointed by dispatch per branch.
REQ-013 SHALL have port count  output  log2(D)+1  number of free tags held.
REQ-014 SHALL have port overflow  output  1  sticky: an enqueue was dropped because list was full.

Function
REQ-015 SHALL be a circular FIFO of D entries; head/tail pointers log2(D)+1 bits, low bits index, MSB wrap.
REQ-016 SHALL drive free_reg combinationally from entry[head index]; count = tail-head (modulo 2^(log2(D)+1)); empty = (count==0).
REQ-017 SHALL, on dequeue_en && !empty, advance head by one at the clock edge; next tag visible the following cycle.
REQ-018 SHALL ignore dequeue_en when empty (no pointer change) unless REQ-027 applies.
REQ-019 SHALL, on enqueue_en with enqueue_pr != 0 and count<D (after same-cycle dequeue), write entry[tail index] and advance tail.
REQ-020 SHALL silently drop enqueue_en with enqueue_pr==0 (zero register never freed; matches ROB ZERO_REG Told).
REQ-021 SHALL drop an enqueue when full with no same-cycle dequeue and set overflow to 1 until reset.
REQ-022 SHALL, when full, accept simultaneous dequeue and enqueue (count unchanged, both pointers advance).
REQ-023 SHALL, on rollback_en, load head <= rollback_head; dequeue_en in that cycle is ignored; enqueue in that cycle still applies to tail.
REQ-024 SHALL wrap both pointers from index D-1 to 0, toggling MSB.

Reset
REQ-025 SHALL on reset: head=0, tail=D (MSB=1, index 0), entry[i]=NUM_AREGS+i, count=D, empty=0, free_reg=NUM_AREGS, head_ptr=0, overflow=0.
REQ-026 SHALL let reset override all other inputs in the same cycle, including mid-rollback.

Configuration
REQ-027 SHALL, with FREE_LIST_BYPASS_EN defined, when empty && enqueue_en && enqueue_pr!=0 && dequeue_en, drive free_reg=enqueue_pr combinationally, report empty=0, and leave both pointers and count unchanged (tag consumed directly).
REQ-028 SHALL, without FREE_LIST_BYPASS_EN, leave empty=1 and ignore dequeue in that case; the enqueue is stored normally.

Verification
REQ-029 SHALL test reset: after reset, free_reg=32, count=32, empty=0, head_ptr=0, overflow=0.
REQ-030 SHALL test drain: 32 consecutive dequeues -> free_reg steps 32..63, then empty=1, count=0; 33rd dequeue leaves head_ptr=32.
REQ-031 SHALL test recycle/wrap: after drain, enqueue 5,9 -> count=2, free_reg=5; dequeue twice -> 5 then 9, head_ptr=34.
REQ-032 SHALL test rollback: head_ptr=0 saved, 3 dequeues, rollback_head=0 with enqueue 7 same cycle -> head_ptr=0, free_reg=32, count=32? no: tail unchanged at full so overflow=1, count=32.
REQ-033 SHALL test zero reg and overflow: enqueue_pr=0 when count=10 -> count stays 10, overflow=0; enqueue 40 when full -> overflow=1 sticky.
REQ-034 SHALL test bypass: empty, enqueue 12 + dequeue same cycle -> with macro free_reg=12, count=0 next cycle; without, free_reg not consumed, count=1 next cycle.
